// File: rtl/cam_capture_gate.sv
// Camera frame capture gate: forwards whole frames only (single-shot or continuous)
// and measures the raw camera frame rate over a one-second window.
module cam_capture_gate #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int DATA_WIDTH  = 24,
  parameter int FPS_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  trigger_capture_frame,
  input  logic                  continuous_capture_frame,
  input  logic                  dma_init_done,
  input  logic                  frame_valid,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  frame_done,
  output logic                  capture_busy,
  output logic [FPS_WIDTH-1:0]  frames_per_second
);

  localparam int TICK_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_FREQ_HZ - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t               state;
  logic                 trigger_d;
  logic                 fv_d;
  logic                 pending;
  logic                 shot;
  logic                 first_pix;
  logic                 trig_rise;
  logic                 fv_rise;
  logic                 fv_fall;
  logic                 capture_window;
  logic                 pix;
  logic [TICK_W-1:0]    tick_cnt;
  logic [FPS_WIDTH-1:0] frame_cnt;
  logic [FPS_WIDTH:0]   fps_sum;

  assign trig_rise      = trigger_capture_frame & ~trigger_d;
  assign fv_rise        = frame_valid & ~fv_d;
  assign fv_fall        = ~frame_valid & fv_d;
  assign capture_window = (state == CAPTURE) | ((state == ARMED) & fv_rise & dma_init_done);
  assign pix            = in_valid & frame_valid & capture_window;
  assign capture_busy   = (state != IDLE);
  assign fps_sum        = {1'b0, frame_cnt} + {{FPS_WIDTH{1'b0}}, fv_rise};

  // shot marks an armed single-shot request; pending records a trigger seen while
  // a frame is being captured and becomes the next shot when that frame ends.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      trigger_d <= 1'b0;
      fv_d      <= 1'b0;
      pending   <= 1'b0;
      shot      <= 1'b0;
    end else begin
      trigger_d <= trigger_capture_frame;
      fv_d      <= frame_valid;
      case (state)
        IDLE: begin
          if (dma_init_done & (continuous_capture_frame | trig_rise)) begin
            state <= ARMED;
            shot  <= trig_rise;
          end
        end
        ARMED: begin
          if (fv_rise & dma_init_done) begin
            state <= CAPTURE;
            shot  <= 1'b0;
          end else if (!dma_init_done) begin
            state   <= IDLE;
            shot    <= 1'b0;
            pending <= 1'b0;
          end else if (!continuous_capture_frame & !shot & !trig_rise) begin
            state <= IDLE;
          end else if (trig_rise) begin
            shot <= 1'b1;
          end
        end
        CAPTURE: begin
          if (fv_fall) begin
            if (dma_init_done & (continuous_capture_frame | pending | trig_rise)) begin
              state <= ARMED;
              shot  <= pending | trig_rise;
            end else begin
              state <= IDLE;
            end
            pending <= 1'b0;
          end else if (trig_rise) begin
            pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A pixel taken in ARMED (the fv_rise cycle) is already the first one, so the
  // first-pixel flag only stays set if that cycle carried no pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      frame_done <= 1'b0;
      first_pix  <= 1'b0;
    end else begin
      out_valid  <= pix;
      out_data   <= in_data;
      out_sof    <= pix & ((state == ARMED) | first_pix);
      frame_done <= (state == CAPTURE) & fv_fall;
      case (state)
        ARMED:   first_pix <= ~pix;
        CAPTURE: first_pix <= first_pix & ~pix;
        default: first_pix <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt          <= '0;
      frame_cnt         <= '0;
      frames_per_second <= '0;
    end else begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt          <= '0;
        frames_per_second <= fps_sum[FPS_WIDTH] ? {FPS_WIDTH{1'b1}} : fps_sum[FPS_WIDTH-1:0];
        frame_cnt         <= {{(FPS_WIDTH-1){1'b0}}, fv_rise};
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
        if (fv_rise & ~(&frame_cnt))
          frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule
